// File: rtl/dfr_reservoir_if.sv
// rtl/dfr_reservoir_if.sv - reservoir handshake and node write-back bundle between the DFR controller and the reservoir engine
interface dfr_reservoir_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_VIRTUAL_NODES = 10
);
    localparam int IDX_W = $clog2(NUM_VIRTUAL_NODES);

    logic                         reservoir_rst;
    logic                         reservoir_en;
    logic [DATA_WIDTH-1:0]        sample_in;
    logic [NUM_VIRTUAL_NODES-1:0] mask_bits;
    logic                         reservoir_busy;
    logic                         reservoir_init_busy;
    logic                         reservoir_valid;
    logic                         reservoir_filled;
    logic                         node_wr;
    logic [IDX_W-1:0]             node_idx;
    logic [DATA_WIDTH-1:0]        node_data;

    modport master (
        output reservoir_rst, reservoir_en, sample_in, mask_bits,
        input  reservoir_busy, reservoir_init_busy, reservoir_valid, reservoir_filled,
        input  node_wr, node_idx, node_data
    );

    modport slave (
        input  reservoir_rst, reservoir_en, sample_in, mask_bits,
        output reservoir_busy, reservoir_init_busy, reservoir_valid, reservoir_filled,
        output node_wr, node_idx, node_data
    );
endinterface

// File: rtl/dfr_reservoir_engine.sv
// rtl/dfr_reservoir_engine.sv - delayed-feedback reservoir step engine; define DFR_RESERVOIR_SAT_EN for saturating node sums
module dfr_reservoir_engine #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int NUM_INIT_SAMPLES  = 4,
    parameter int NUM_SAMPLES       = 16,
    parameter int FB_SHIFT          = 1,
    parameter int PIPE_STAGES       = 2
) (
    input  logic             clk,
    input  logic             rst,
    dfr_reservoir_if.slave   bus
);
    localparam int W      = DATA_WIDTH;
    localparam int N      = NUM_VIRTUAL_NODES;
    localparam int P      = PIPE_STAGES;
    localparam int IDX_W  = $clog2(N);
    localparam int TOTAL  = NUM_INIT_SAMPLES + NUM_SAMPLES;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int DR_W   = $clog2(P + 1);

    localparam logic [IDX_W-1:0] LAST_NODE  = IDX_W'(N - 1);
    localparam logic [DR_W-1:0]  LAST_DRAIN = DR_W'(P - 1);
    localparam logic [CNT_W-1:0] INIT_C     = CNT_W'(NUM_INIT_SAMPLES);
    localparam logic [CNT_W-1:0] TOTAL_C    = CNT_W'(TOTAL);
    localparam logic             INIT_BUSY_RST = (NUM_INIT_SAMPLES != 0);

    typedef enum logic [1:0] {IDLE, PROCESS, DRAIN, VALID} state_t;

    // Either reset source clears the whole engine, including a step in flight.
    logic clr;
    assign clr = rst | bus.reservoir_rst;

    state_t                  state;
    logic [CNT_W-1:0]        step_cnt;
    logic [IDX_W-1:0]        node_cnt;
    logic [DR_W-1:0]         drain_cnt;
    logic signed [W-1:0]     s_reg;
    logic [N-1:0]            mask_reg;
    logic                    busy_r;
    logic                    init_busy_r;
    logic                    filled_r;
    logic                    valid_r;

    logic signed [W-1:0]     delay_line [N];

    logic                    pipe_v    [P];
    logic [IDX_W-1:0]        pipe_idx  [P];
    logic [W-1:0]            pipe_data [P];

    logic signed [W-1:0]     fb;
    logic [W-1:0]            node_x;
    logic [CNT_W-1:0]        step_next;

    // Node sum for the current virtual node: masked sample plus attenuated delayed node.
`ifdef DFR_RESERVOIR_SAT_EN
    logic signed [W:0]       s_ext;
    logic signed [W:0]       addend;
    logic signed [W:0]       sum;
    always_comb begin
        fb     = delay_line[node_cnt] >>> FB_SHIFT;
        s_ext  = {s_reg[W-1], s_reg};
        addend = mask_reg[node_cnt] ? s_ext : -s_ext;
        sum    = addend + {fb[W-1], fb};
        // Top two bits disagree only when the sum left the W-bit range.
        if (sum[W] != sum[W-1]) begin
            node_x = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            node_x = sum[W-1:0];
        end
    end
`else
    logic signed [W-1:0]     addend;
    always_comb begin
        // Low W bits of a W+1-bit sum equal a plain W-bit modular sum.
        fb     = delay_line[node_cnt] >>> FB_SHIFT;
        addend = mask_reg[node_cnt] ? s_reg : -s_reg;
        node_x = addend + fb;
    end
`endif

    // Saturating step counter value to commit when a step completes.
    always_comb begin
        step_next = (step_cnt == TOTAL_C) ? step_cnt : step_cnt + 1'b1;
    end

    // Step sequencer with registered handshake flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            step_cnt    <= '0;
            node_cnt    <= '0;
            drain_cnt   <= '0;
            s_reg       <= '0;
            mask_reg    <= '0;
            busy_r      <= 1'b1;
            init_busy_r <= INIT_BUSY_RST;
            filled_r    <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.reservoir_en && busy_r) begin
                        s_reg    <= bus.sample_in;
                        mask_reg <= bus.mask_bits;
                        node_cnt <= '0;
                        state    <= PROCESS;
                    end
                end
                PROCESS: begin
                    if (node_cnt == LAST_NODE) begin
                        node_cnt  <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        node_cnt <= node_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        valid_r <= 1'b1;
                        state   <= VALID;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                VALID: begin
                    valid_r     <= 1'b0;
                    step_cnt    <= step_next;
                    init_busy_r <= (step_next < INIT_C);
                    busy_r      <= (step_next < TOTAL_C);
                    filled_r    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back pipeline: a node issued in PROCESS emerges P cycles later.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < P; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_idx[i]  <= '0;
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_v[0]    <= (state == PROCESS);
            pipe_idx[0]  <= node_cnt;
            pipe_data[0] <= node_x;
            for (int i = 1; i < P; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_idx[i]  <= pipe_idx[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Delay line captures each node result as it is written back.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                delay_line[i] <= '0;
            end
        end else if (pipe_v[P-1]) begin
            delay_line[pipe_idx[P-1]] <= pipe_data[P-1];
        end
    end

    assign bus.reservoir_busy      = busy_r;
    assign bus.reservoir_init_busy = init_busy_r;
    assign bus.reservoir_valid     = valid_r;
    assign bus.reservoir_filled    = filled_r;
    assign bus.node_wr             = pipe_v[P-1];
    assign bus.node_idx            = pipe_idx[P-1];
    assign bus.node_data           = pipe_data[P-1];
endmodule

// File: tb/tb_dfr_reservoir_engine.sv
// tb/tb_dfr_reservoir_engine.sv - scoreboard bench for dfr_reservoir_engine
module tb_dfr_reservoir_engine;
    localparam int W     = 32;
    localparam int N     = 10;
    localparam int P     = 2;
    localparam int NINIT = 4;
    localparam int NSAMP = 16;
    localparam int FBS   = 1;
    localparam int TOTAL = NINIT + NSAMP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfr_reservoir_if #(.DATA_WIDTH(W), .NUM_VIRTUAL_NODES(N)) bus ();

    dfr_reservoir_engine #(
        .DATA_WIDTH(W), .NUM_VIRTUAL_NODES(N), .NUM_INIT_SAMPLES(NINIT),
        .NUM_SAMPLES(NSAMP), .FB_SHIFT(FBS), .PIPE_STAGES(P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    int           q_idx[$];
    logic [W-1:0] q_data[$];
    longint       mdl_delay [N];
    int           mdl_steps;
    bit           mdl_filled;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] reduce(input longint v);
        logic [63:0] t;
`ifdef DFR_RESERVOIR_SAT_EN
        if (v > 64'sd2147483647)       v = 64'sd2147483647;
        else if (v < -64'sd2147483648) v = -64'sd2147483648;
`endif
        t = v;
        return t[W-1:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) mdl_delay[k] = 0;
        mdl_steps  = 0;
        mdl_filled = 0;
        q_idx.delete();
        q_data.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("rst_busy",      64'(bus.reservoir_busy),      64'(1));
        check("rst_init_busy", 64'(bus.reservoir_init_busy), 64'(1));
        check("rst_filled",    64'(bus.reservoir_filled),    64'(0));
        check("rst_valid",     64'(bus.reservoir_valid),     64'(0));
        check("rst_node_wr",   64'(bus.node_wr),             64'(0));
        check("rst_node_idx",  64'(bus.node_idx),            64'(0));
        check("rst_node_data", 64'(bus.node_data),           64'(0));
    endtask

    // One step request; abort_at>0 pulses reservoir_rst in that cycle, re_pulse re-requests mid-step.
    task automatic do_step(input logic [W-1:0] s, input logic [N-1:0] m, input int abort_at, input bit re_pulse);
        bit     accept;
        bit     filled_before;
        int     vcnt;
        int     exp_v;
        int     idx;
        longint sl;
        longint x;
        logic [W-1:0] d;
        accept        = (mdl_steps < TOTAL);
        filled_before = mdl_filled;
        vcnt          = 0;
        exp_v         = accept ? 1 : 0;
        @(negedge clk);
        bus.sample_in    = s;
        bus.mask_bits    = m;
        bus.reservoir_en = 1'b1;
        if (accept) begin
            sl = longint'($signed(s));
            for (int k = 0; k < N; k++) begin
                x = (m[k] ? sl : -sl) + (mdl_delay[k] >>> FBS);
                d = reduce(x);
                mdl_delay[k] = longint'($signed(d));
                q_idx.push_back(k);
                q_data.push_back(d);
            end
        end
        @(posedge clk);
        for (int c = 1; c <= N + P + 3; c++) begin
            @(negedge clk);
            if (bus.node_wr) begin
                if (q_idx.size() == 0) begin
                    check("node_wr_unexpected", 64'(1), 64'(0));
                end else begin
                    idx = q_idx.pop_front();
                    d   = q_data.pop_front();
                    check("node_idx",   64'(bus.node_idx),  64'(idx));
                    check("node_data",  64'(bus.node_data), 64'(d));
                    check("node_cycle", 64'(c),             64'(1 + idx + P));
                end
            end
            if (bus.reservoir_valid) begin
                vcnt++;
                check("valid_cycle", 64'(c), 64'(N + P + 1));
            end
            if (accept && abort_at == 0 && c == N + P + 1)
                check("filled_before_flag", 64'(bus.reservoir_filled), 64'(filled_before));
            bus.reservoir_en = re_pulse && (c == 3 || c == N + 1 || c == N + P + 1);
            if (c == abort_at) begin
                bus.reservoir_rst = 1'b1;
                model_clear();
                exp_v = 0;
            end else begin
                bus.reservoir_rst = 1'b0;
            end
        end
        if (exp_v == 1) begin
            if (mdl_steps < TOTAL) mdl_steps++;
            mdl_filled = 1;
        end
        check("valid_count",   64'(vcnt),          64'(exp_v));
        check("pending_nodes", 64'(q_idx.size()),  64'(0));
        q_idx.delete();
        q_data.delete();
        check("busy",      64'(bus.reservoir_busy),      64'(mdl_steps < TOTAL));
        check("init_busy", 64'(bus.reservoir_init_busy), 64'(mdl_steps < NINIT));
        check("filled",    64'(bus.reservoir_filled),    64'(mdl_filled));
    endtask

    initial begin
        bus.reservoir_rst = 1'b0;
        bus.reservoir_en  = 1'b0;
        bus.sample_in     = '0;
        bus.mask_bits     = '0;
        model_clear();

        do_reset();
        do_step(32'd100, '1, 0, 0);
        do_step(32'd100, '1, 0, 0);

        do_reset();
        do_step(32'd100, '1, 0, 0);
        do_step(32'd100, 10'h155, 0, 0);
        do_step(32'd77, 10'h2C3, 0, 1);

        do_reset();
        do_step(32'h7FFF_FFFF, '1, 0, 0);
        do_step(32'h7FFF_FFFF, '1, 0, 0);
        do_reset();
        do_step(32'h8000_0000, '0, 0, 0);
        do_step(32'h8000_0000, '0, 0, 0);

        do_reset();
        do_step(32'd100, '1, 0, 0);
        do_step(32'd55, 10'h2AA, 6, 0);
        do_step(32'd100, '1, 0, 0);

        do_reset();
        for (int i = 0; i < TOTAL; i++) begin
            do_step(W'($urandom()), N'($urandom()), 0, 0);
        end
        do_step(32'd123, '1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dfr_reservoir_engine.md
Name: dfr_reservoir_engine

Overview:
Responder side of the DFR core controller's reservoir handshake. Consumes reservoir_rst/reservoir_en requests and answers with reservoir_busy, reservoir_init_busy, reservoir_valid and reservoir_filled. Each accepted request takes one input sample and time-multiplexes it across NUM_VIRTUAL_NODES virtual nodes of a delayed-feedback reservoir, one node per cycle. Each node result is streamed to the reservoir history buffer.

Parameters:
DATA_WIDTH, 32, signed node/sample width
NUM_VIRTUAL_NODES, 10, virtual nodes per reservoir step (>=2)
NUM_INIT_SAMPLES, 4, warm-up steps before reservoir_init_busy drops
NUM_SAMPLES, 16, steps after warm-up before reservoir_busy drops
FB_SHIFT, 1, feedback attenuation, arithmetic right shift of delayed node
PIPE_STAGES, 2, register stages between node sum and write-back (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
reservoir_rst  in  1  sync clear of counters, delay line and flags, same effect as rst
reservoir_en  in  1  step request, 1-cycle pulse
sample_in  in  DATA_WIDTH  signed input sample, captured when reservoir_en is accepted
mask_bits  in  NUM_VIRTUAL_NODES  per-node input mask: 1 = +sample, 0 = -sample; captured with sample_in
reservoir_busy  out  1  high while completed steps < NUM_INIT_SAMPLES+NUM_SAMPLES
reservoir_init_busy  out  1  high while completed steps < NUM_INIT_SAMPLES
reservoir_valid  out  1  1-cycle pulse, step complete
reservoir_filled  out  1  high once at least one step has completed since reset
node_wr  out  1  node result strobe
node_idx  out  $clog2(NUM_VIRTUAL_NODES)  index of node_data
node_data  out  DATA_WIDTH  node result

Behaviour:
- Reset values (rst or reservoir_rst): state IDLE, step counter 0, node counter 0, delay line all 0. Outputs after reset: reservoir_busy=1, reservoir_init_busy=1 (0 if NUM_INIT_SAMPLES=0), filled=0, valid=0, node_wr=0, node_idx=0, node_data=0. Reset wins over everything, including mid-step; a reset in flight discards the step and no valid is produced.
- FSM states: IDLE, PROCESS, DRAIN, VALID.
- IDLE: reservoir_en && reservoir_busy -> capture sample_in and mask_bits, node counter=0, go to PROCESS. reservoir_en while !reservoir_busy is ignored: no state change, no valid.
- PROCESS: each cycle k = 0..NUM_VIRTUAL_NODES-1, compute x_k = (mask[k] ? s : -s) + (delay[k] >>> FB_SHIFT) and push it into the pipeline. After node NUM_VIRTUAL_NODES-1, go to DRAIN.
- DRAIN: wait until the pipeline is empty (PIPE_STAGES cycles), then go to VALID.
- VALID: reservoir_valid=1 for exactly one cycle, step counter +1 (saturates at NUM_INIT_SAMPLES+NUM_SAMPLES), filled set, return to IDLE.
- Pipeline output: node_wr=1 with node_idx=k and node_data=x_k exactly PIPE_STAGES cycles after node k enters. The same cycle writes delay[k] <= x_k.
- Latency: reservoir_en accepted in cycle 0; node k strobes at cycle 1+k+PIPE_STAGES; reservoir_valid asserts at cycle NUM_VIRTUAL_NODES+PIPE_STAGES+1.
- reservoir_en in PROCESS/DRAIN/VALID is ignored. No queueing.
- Flags are registered and update the cycle after VALID:
  - reservoir_init_busy falls when step counter == NUM_INIT_SAMPLES.
  - reservoir_busy falls when step counter == NUM_INIT_SAMPLES+NUM_SAMPLES.
- Arithmetic: negation and addition are done at DATA_WIDTH+1 bits, then reduced per the optional feature. -(-2^(W-1)) is handled by the same rule.

Optional Feature:
DFR_RESERVOIR_SAT_EN
- Defined: the DATA_WIDTH+1-bit sum saturates to [-2^(W-1), 2^(W-1)-1]. This acts as the reservoir nonlinearity.
- Undefined: the sum wraps modulo 2^DATA_WIDTH (low bits kept).
- Latency and handshake are identical in both builds.

Test Plan:
- Reset then one step with W=32, N=10, P=2, sample_in=100, mask=all 1s -> node_wr at cycles 3..12 with data 100 for idx 0..9; valid pulses only at cycle 13; filled=1 from cycle 14.
- Second step with sample_in=100, same mask, FB_SHIFT=1 -> every node_data=150; alternating mask (0x155) -> even idx 150, odd idx -50.
- Full run, NUM_INIT_SAMPLES=4, NUM_SAMPLES=16 -> init_busy drops after the 4th valid; busy drops after the 20th; a 21st reservoir_en produces no valid and no node_wr.
- sample_in=0x7FFFFFFF twice, mask all 1s -> second step node_data=0x7FFFFFFF with SAT_EN; 0xBFFFFFFE without. sample_in=0x80000000 with mask 0 -> 0x7FFFFFFF with SAT_EN; 0x80000000 without.
- reservoir_en pulsed again during PROCESS and DRAIN -> ignored; exactly 10 node_wr and one valid.
- reservoir_rst asserted at cycle 6 of a step -> no valid and node_wr=0 from the next cycle; counters 0, filled=0, busy=1; next step node_data equals the sample with no feedback.
